// File: rtl/mvu_weight_loader.sv
// Runtime weight loader: scatters a valid/ready stream of SIMD*TW-bit words into PE weight memories, PE index innermost.
// Optional XOR checksum of the accepted words is enabled with `define WLOAD_CHECKSUM_EN.
module mvu_weight_loader #(
    parameter int PE           = 2,
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
    parameter int PE_BW        = (PE > 1) ? $clog2(PE) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [SIMD*TW-1:0]      s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
`ifdef WLOAD_CHECKSUM_EN
    output logic [SIMD*TW-1:0]      checksum,
`endif
    output logic [SIMD*TW-1:0]      wmem_wdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [1:0]              state;
    logic [PE_BW-1:0]        pe_cnt;
    logic [WMEM_ADDR_BW-1:0] addr_cnt;
    logic                    accept;
    logic                    last_beat;
    logic [PE-1:0]           we_next;

    assign s_tready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = s_tready && s_tvalid;
    assign last_beat = accept && (pe_cnt == PE_LAST) && (addr_cnt == ADDR_LAST);

    // One-hot decode of the PE counter; at most one bit can ever match.
    for (genvar p = 0; p < PE; p++) begin : g_we
        assign we_next[p] = accept && (pe_cnt == PE_BW'(p));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= LOAD;
                LOAD:    if (last_beat) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pe_cnt   <= '0;
            addr_cnt <= '0;
        end else if (state == IDLE && start) begin
            pe_cnt   <= '0;
            addr_cnt <= '0;
        end else if (accept) begin
            if (pe_cnt == PE_LAST) begin
                pe_cnt   <= '0;
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
            end else begin
                pe_cnt <= pe_cnt + 1'b1;
            end
        end
    end

    // Write port is registered: each strobe trails its acceptance by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wmem_we    <= '0;
            wmem_waddr <= '0;
            wmem_wdata <= '0;
        end else begin
            wmem_we <= we_next;
            if (accept) begin
                wmem_waddr <= addr_cnt;
                wmem_wdata <= s_tdata;
            end
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (state == IDLE && start)
            checksum <= '0;
        else if (accept)
            checksum <= checksum ^ s_tdata;
    end
`endif

endmodule

// File: tb/tb_mvu_weight_loader.sv
// Directed bench for mvu_weight_loader: a PE=2/DEPTH=4 instance and a PE=3/DEPTH=3 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mvu_weight_loader;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // PE=2, WMEM_DEPTH=4 instance
    logic       start, busy, done, s_tvalid, s_tready;
    logic [1:0] s_tdata, wmem_we, wmem_waddr, wmem_wdata;
`ifdef WLOAD_CHECKSUM_EN
    logic [1:0] checksum;
`endif

    // PE=3, WMEM_DEPTH=3 instance
    logic       start3, busy3, done3, s_tvalid3, s_tready3;
    logic [1:0] s_tdata3, wmem_waddr3, wmem_wdata3;
    logic [2:0] wmem_we3;
`ifdef WLOAD_CHECKSUM_EN
    logic [1:0] checksum3;
`endif

    mvu_weight_loader #(.PE(2), .SIMD(2), .TW(1), .WMEM_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .wmem_we(wmem_we), .wmem_waddr(wmem_waddr),
`ifdef WLOAD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .wmem_wdata(wmem_wdata)
    );

    mvu_weight_loader #(.PE(3), .SIMD(2), .TW(1), .WMEM_DEPTH(3)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .busy(busy3), .done(done3),
        .s_tdata(s_tdata3), .s_tvalid(s_tvalid3), .s_tready(s_tready3),
        .wmem_we(wmem_we3), .wmem_waddr(wmem_waddr3),
`ifdef WLOAD_CHECKSUM_EN
        .checksum(checksum3),
`endif
        .wmem_wdata(wmem_wdata3)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] wd [8];
    logic [1:0] csum_exp;
    bit         csum_chk;

    // Hand-computed strobe tables
    logic [1:0] we_tab2   [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] addr_tab2 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [2:0] we_tab3   [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] addr_tab3 [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [1:0] data_tab3 [9] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n beats of wd[] on the PE=2 instance; optional idle gaps and a start pulse at beat 3.
    task automatic run_load(input bit gaps, input bit restart3, input int n);
        @(negedge clock); start = 1'b1;
        @(posedge clock); @(negedge clock); start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_tready", s_tready, 1);
        chk("load_we_idle", wmem_we, 0);
        chk("load_done_idle", done, 0);
        for (int k = 0; k < n; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = wd[k];
            start    = restart3 && (k == 3);
            @(posedge clock); @(negedge clock);
            start = 1'b0;
            chk($sformatf("we_b%0d", k), wmem_we, we_tab2[k]);
            chk($sformatf("addr_b%0d", k), wmem_waddr, addr_tab2[k]);
            chk($sformatf("data_b%0d", k), wmem_wdata, wd[k]);
            chk($sformatf("done_b%0d", k), done, (k == 7));
            chk($sformatf("tready_b%0d", k), s_tready, (k != 7));
            chk($sformatf("busy_b%0d", k), busy, 1);
`ifdef WLOAD_CHECKSUM_EN
            if (csum_chk && k == 7) chk("checksum_done", checksum, csum_exp);
`endif
            if (gaps && k != 7) begin
                s_tvalid = 1'b0;
                @(posedge clock); @(negedge clock);
                chk($sformatf("gap_we_b%0d", k), wmem_we, 0);
                chk($sformatf("gap_done_b%0d", k), done, 0);
            end
        end
        if (n == 8) begin
            s_tvalid = 1'b0;
            @(posedge clock); @(negedge clock);
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
            chk("post_tready", s_tready, 0);
            chk("post_we", wmem_we, 0);
`ifdef WLOAD_CHECKSUM_EN
            if (csum_chk) chk("checksum_hold", checksum, csum_exp);
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        start3 = 1'b0; s_tvalid3 = 1'b0; s_tdata3 = '0;
        csum_chk = 1'b0; csum_exp = '0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_we", wmem_we, 0);
        chk("rst_waddr", wmem_waddr, 0);
        chk("rst_wdata", wmem_wdata, 0);
        chk("rst_we3", wmem_we3, 0);
        chk("rst_busy3", busy3, 0);
        @(negedge clock); reset = 1'b0;

        // Valid in IDLE without start: nothing accepted
        s_tvalid = 1'b1; s_tdata = 2'd3;
        repeat (2) begin
            @(posedge clock); @(negedge clock);
            chk("idle_we", wmem_we, 0);
            chk("idle_tready", s_tready, 0);
        end
        s_tvalid = 1'b0;

        // Back-to-back load
        wd = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        run_load(1'b0, 1'b0, 8);

        // Valid toggling every other cycle
        wd = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
        run_load(1'b1, 1'b0, 8);

        // start pulsed mid-load is ignored
        wd = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2};
        run_load(1'b0, 1'b1, 8);

        // Reset after beat 5, then a clean reload from PE 0 / address 0
        wd = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
        run_load(1'b0, 1'b0, 5);
        reset = 1'b1; s_tvalid = 1'b0;
        #1;
        chk("mid_rst_we", wmem_we, 0);
        chk("mid_rst_tready", s_tready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_waddr", wmem_waddr, 0);
        @(posedge clock); @(negedge clock);
        chk("rst_hold_we", wmem_we, 0);
        reset = 1'b0;
        run_load(1'b0, 1'b0, 8);

        // Checksum loads (only compared when the feature is built in)
        csum_chk = 1'b1;
        wd = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        csum_exp = 2'd0;
        run_load(1'b0, 1'b0, 8);
        wd = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        csum_exp = 2'd1;
        run_load(1'b0, 1'b0, 8);
        csum_chk = 1'b0;

        // PE=3, WMEM_DEPTH=3: 9 beats, address never reaches 3
        @(negedge clock); start3 = 1'b1;
        @(posedge clock); @(negedge clock); start3 = 1'b0;
        chk("p3_tready", s_tready3, 1);
        for (int k = 0; k < 9; k++) begin
            s_tvalid3 = 1'b1;
            s_tdata3  = data_tab3[k];
            @(posedge clock); @(negedge clock);
            chk($sformatf("p3_we_b%0d", k), wmem_we3, we_tab3[k]);
            chk($sformatf("p3_addr_b%0d", k), wmem_waddr3, addr_tab3[k]);
            chk($sformatf("p3_data_b%0d", k), wmem_wdata3, data_tab3[k]);
            chk($sformatf("p3_done_b%0d", k), done3, (k == 8));
            chk($sformatf("p3_tready_b%0d", k), s_tready3, (k != 8));
        end
        @(posedge clock); @(negedge clock);
        s_tvalid3 = 1'b0;
        chk("p3_post_we", wmem_we3, 0);
        chk("p3_post_busy", busy3, 0);
        chk("p3_post_tready", s_tready3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
